// File: rtl/button_gesture.sv
// Gesture classifier for debounced button edge pulses: short, double and long press,
// plus auto-repeat while held. All event outputs are registered one-cycle pulses.
module button_gesture #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int LONG_MS   = 600,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_rise,
  input  logic btn_fall,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic pressed
);

  localparam int CPM     = CLK_FREQ / 1000;
  localparam int MAX_MS1 = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
  localparam int MAX_MS  = (MAX_MS1 > REPEAT_MS) ? MAX_MS1 : REPEAT_MS;
  localparam int TW      = $clog2(MAX_MS * CPM) + 1;

  localparam logic [TW-1:0] LONG_END   = TW'(LONG_MS * CPM - 1);
  localparam logic [TW-1:0] DOUBLE_END = TW'(DOUBLE_MS * CPM - 1);
  localparam logic [TW-1:0] REPEAT_END = TW'(REPEAT_MS * CPM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_REPEAT,
    S_WAIT_REL
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic          w_rise;
  logic          w_fall;
  logic          w_clr;
  logic          w_short;
  logic          w_double;
  logic          w_long;
  logic          w_repeat;

  // Simultaneous rise and fall carry no information and are treated as no event.
  assign w_rise = btn_rise & ~btn_fall;
  assign w_fall = btn_fall & ~btn_rise;

  always_comb begin
    w_next   = r_state;
    w_clr    = 1'b0;
    w_short  = 1'b0;
    w_double = 1'b0;
    w_long   = 1'b0;
    w_repeat = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_rise) w_next = S_PRESS;
      end
      S_PRESS: begin
        if (w_fall) begin
          w_next = S_GAP;
        end else if (r_timer == LONG_END) begin
          w_next = S_REPEAT;
          w_long = 1'b1;
        end
      end
      S_GAP: begin
        if (w_rise) begin
          w_next   = S_WAIT_REL;
          w_double = 1'b1;
        end else if (r_timer == DOUBLE_END) begin
          w_next  = S_IDLE;
          w_short = 1'b1;
        end
      end
      S_REPEAT: begin
        if (w_fall) begin
          w_next = S_IDLE;
        end else if (r_timer == REPEAT_END) begin
          w_clr    = 1'b1;
          w_repeat = 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (w_fall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_next != r_state) w_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      pressed      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_timer      <= w_clr ? '0 : r_timer + 1'b1;
      short_press  <= w_short;
      double_press <= w_double;
      long_press   <= w_long;
      repeat_pulse <= w_repeat;
      pressed      <= (w_next == S_PRESS) || (w_next == S_REPEAT) || (w_next == S_WAIT_REL);
    end
  end

endmodule
